r_wptr_sync_decoder: RTL and testbench

- Read-domain receiver for the write-side Gray pointer of the asynchronous FIFO.
- Synchronises G_WPTR (launched in the write clock domain) into R_CLK, then decodes Gray to binary.
- Produces G_WPTR_SYNC, which the read pointer handler consumes for EMPTY generation.
- Also provides the combinational next-empty term, a registered fill level, an almost-empty flag and a sticky underflow flag for the read side.

---
 rtl/async_fifo_pkg.sv | 26 ++
 rtl/cdc_sync_bus.sv | 34 +++
 rtl/r_wptr_sync_decoder.sv | 125 ++++++++++++
 tb/tb_r_wptr_sync_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: pointer type and Gray/binary helpers shared by both FIFO clock domains.
`default_nettype none

package async_fifo_pkg;

    localparam int PTR_WIDTH = 10;
    localparam int DEPTH     = 2 ** (PTR_WIDTH - 1);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_sync_bus.sv
// cdc_sync_bus: plain multi-flop synchroniser chain for a Gray-coded bus.
`default_nettype none

module cdc_sync_bus #(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Stages connect flop-to-flop only; any logic here would break the CDC guarantee.
    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/r_wptr_sync_decoder.sv
// r_wptr_sync_decoder: syncs the write Gray pointer into R_CLK, decodes it, derives empty/level/flags.
// Optional macro R_WPTR_GRAY_CHECK_EN adds the sticky R_GRAY_ERR output.
`default_nettype none

module r_wptr_sync_decoder #(
    parameter int PTR_WIDTH   = async_fifo_pkg::PTR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 4
) (
    input  logic                 R_CLK,
    input  logic                 RRST_n,
    input  logic [PTR_WIDTH-1:0] G_WPTR,
    input  logic [PTR_WIDTH-1:0] R_PTR_NXT,
    input  logic [PTR_WIDTH-1:0] R_PTR,
    input  logic                 R_EN,
    input  logic                 EMPTY,
    input  logic                 R_UNDERFLOW_CLR,
    output logic [PTR_WIDTH-1:0] G_WPTR_SYNC,
    output logic [PTR_WIDTH-1:0] B_WPTR_SYNC,
    output logic                 R_EMPTY,
    output logic [PTR_WIDTH-1:0] R_LEVEL,
    output logic                 R_ALMOST_EMPTY,
    output logic                 R_UNDERFLOW
`ifdef R_WPTR_GRAY_CHECK_EN
    ,
    output logic                 R_GRAY_ERR
`endif
);

    import async_fifo_pkg::*;

    localparam logic [PTR_WIDTH:0] AE_LIM = (PTR_WIDTH + 1)'(AE_THRESH);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("SYNC_STAGES must be within 2..4");
    end
    if (AE_THRESH < 0 || AE_THRESH > 2 ** (PTR_WIDTH - 1)) begin : g_bad_thresh
        $error("AE_THRESH must be within 0..DEPTH");
    end
    if (PTR_WIDTH < 2 || PTR_WIDTH > $bits(ptr_t)) begin : g_bad_width
        $error("PTR_WIDTH must be within 2..width of async_fifo_pkg::ptr_t");
    end

    logic [PTR_WIDTH-1:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH-1:0] level_q;
    logic                 ae_q, ae_d;
    logic                 uf_q, uf_d;
    logic [PTR_WIDTH-1:0] w_diff;
    logic                 w_unused;

    cdc_sync_bus #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (R_CLK),
        .rst_n_i (RRST_n),
        .d_i     (G_WPTR),
        .q_o     (G_WPTR_SYNC)
    );

    // Zero-extension into ptr_t leaves the Gray decode of the low bits unchanged.
    assign b_wptr_d = PTR_WIDTH'(gray2bin(ptr_t'(G_WPTR_SYNC)));
    assign w_diff   = B_WPTR_SYNC - R_PTR_NXT;
    assign ae_d     = ({1'b0, w_diff} <= AE_LIM);
    assign uf_d     = (R_EN & EMPTY) | (uf_q & ~R_UNDERFLOW_CLR);

    always_ff @(posedge R_CLK or negedge RRST_n) begin
        if (!RRST_n) begin
            b_wptr_q <= '0;
            level_q  <= '0;
            ae_q     <= 1'b1;
            uf_q     <= 1'b0;
        end else begin
            b_wptr_q <= b_wptr_d;
            level_q  <= w_diff;
            ae_q     <= ae_d;
            uf_q     <= uf_d;
        end
    end

    assign B_WPTR_SYNC    = b_wptr_q;
    assign R_EMPTY        = (R_PTR_NXT == b_wptr_q);
    assign R_LEVEL        = level_q;
    assign R_ALMOST_EMPTY = ae_q;
    assign R_UNDERFLOW    = uf_q;

    // R_PTR is carried for interface symmetry with the read pointer handler only.
    assign w_unused = ^R_PTR;

`ifdef R_WPTR_GRAY_CHECK_EN
    logic [PTR_WIDTH-1:0] prev_gsync_q;
    logic                 gray_err_q, gray_err_d;
    logic [PTR_WIDTH-1:0] w_flip;
    logic                 w_gray_bad;

    assign w_flip     = prev_gsync_q ^ G_WPTR_SYNC;
    // More than one bit set iff clearing the lowest set bit leaves something behind.
    assign w_gray_bad = |(w_flip & (w_flip - PTR_WIDTH'(1)));
    assign gray_err_d = w_gray_bad | (gray_err_q & ~R_UNDERFLOW_CLR);

    always_ff @(posedge R_CLK or negedge RRST_n) begin
        if (!RRST_n) begin
            prev_gsync_q <= '0;
            gray_err_q   <= 1'b0;
        end else begin
            prev_gsync_q <= G_WPTR_SYNC;
            gray_err_q   <= gray_err_d;
        end
    end

    assign R_GRAY_ERR = gray_err_q;

`ifndef SYNTHESIS
    always_ff @(posedge R_CLK) begin
        if (RRST_n) begin
            assert (!w_gray_bad)
            else $error("G_WPTR_SYNC multi-bit step: prev=%h now=%h", prev_gsync_q, G_WPTR_SYNC);
        end
    end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_r_wptr_sync_decoder.sv
// tb_r_wptr_sync_decoder: directed and random stimulus checked against a delayed-history reference model.
`default_nettype none

module tb_r_wptr_sync_decoder;

    localparam int S  = 2;
    localparam int AE = 4;

    logic       R_CLK = 1'b0;
    logic       RRST_n;
    logic [9:0] G_WPTR = '0, R_PTR_NXT = '0, R_PTR = '0;
    logic       R_EN = 1'b0, EMPTY = 1'b0, R_UNDERFLOW_CLR = 1'b0;
    logic [9:0] G_WPTR_SYNC, B_WPTR_SYNC, R_LEVEL;
    logic       R_EMPTY, R_ALMOST_EMPTY, R_UNDERFLOW;
`ifdef R_WPTR_GRAY_CHECK_EN
    logic       gray_err;
`endif

    r_wptr_sync_decoder #(
        .PTR_WIDTH   (10),
        .SYNC_STAGES (S),
        .AE_THRESH   (AE)
    ) dut (
        .R_CLK           (R_CLK),
        .RRST_n          (RRST_n),
        .G_WPTR          (G_WPTR),
        .R_PTR_NXT       (R_PTR_NXT),
        .R_PTR           (R_PTR),
        .R_EN            (R_EN),
        .EMPTY           (EMPTY),
        .R_UNDERFLOW_CLR (R_UNDERFLOW_CLR),
        .G_WPTR_SYNC     (G_WPTR_SYNC),
        .B_WPTR_SYNC     (B_WPTR_SYNC),
        .R_EMPTY         (R_EMPTY),
        .R_LEVEL         (R_LEVEL),
        .R_ALMOST_EMPTY  (R_ALMOST_EMPTY),
        .R_UNDERFLOW     (R_UNDERFLOW)
`ifdef R_WPTR_GRAY_CHECK_EN
        ,
        .R_GRAY_ERR      (gray_err)
`endif
    );

    always #5 R_CLK = ~R_CLK;

    int         nchk = 0;
    int         nfail = 0;
    int         k = 0;           // edges since last reset release
    logic [9:0] gh [0:4095];     // G_WPTR sampled at edge n
    logic [9:0] ph [0:4095];     // R_PTR_NXT sampled at edge n
    logic       muf = 1'b0;

    function automatic logic [9:0] g2b(input logic [9:0] g);
        logic [9:0] b = '0;
        for (int i = 0; i < 10; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [9:0] b2g(input logic [9:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [9:0] exp_gs(input int n);
        return (n >= S) ? gh[n-S+1] : 10'h000;
    endfunction

    function automatic logic [9:0] exp_b(input int n);
        return (n >= S + 1) ? g2b(gh[n-S]) : 10'h000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_all();
        logic [9:0] lv;
        lv = (k >= 1) ? (exp_b(k - 1) - ph[k]) : 10'h000;
        chk("g_wptr_sync", 32'(G_WPTR_SYNC), 32'(exp_gs(k)));
        chk("b_wptr_sync", 32'(B_WPTR_SYNC), 32'(exp_b(k)));
        chk("r_empty", 32'(R_EMPTY), 32'(R_PTR_NXT == exp_b(k)));
        chk("r_level", 32'(R_LEVEL), 32'(lv));
        chk("r_almost_empty", 32'(R_ALMOST_EMPTY), 32'((k >= 1) ? (lv <= 10'(AE)) : 1'b1));
        chk("r_underflow", 32'(R_UNDERFLOW), 32'(muf));
    endtask

    task automatic tick();
        logic nuf;
        if (k >= 4094) begin
            $display("FAIL history_overflow observed=%0d expected<4094", k);
            $fatal(1, "history overflow");
        end
        gh[k+1] = G_WPTR;
        ph[k+1] = R_PTR_NXT;
        nuf = (R_EN & EMPTY) | (muf & ~R_UNDERFLOW_CLR);
        @(posedge R_CLK);
        #1;
        k++;
        muf = nuf;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RRST_n = 1'b0;
        #2;
        k = 0;
        muf = 1'b0;
        check_all();
        @(negedge R_CLK);
        RRST_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wb, rb;
        RRST_n = 1'b1;
        #1;

        // Reset with all-ones Gray pointer held
        G_WPTR = 10'h3FF;
        do_reset();
        ticks(2);
        chk("tp_gsync_3ff", 32'(G_WPTR_SYNC), 32'h3FF);
        tick();
        chk("tp_bsync_2aa", 32'(B_WPTR_SYNC), 32'h2AA);
        ticks(2);

        // Write side counts 0..20, reader idle
        G_WPTR = '0;
        do_reset();
        for (int w = 1; w <= 20; w++) begin
            G_WPTR = b2g(10'(w));
            tick();
        end
        ticks(5);
        chk("tp_level_20", 32'(R_LEVEL), 32'd20);
        chk("tp_ae_low", 32'(R_ALMOST_EMPTY), 32'd0);

        // Fill to DEPTH, then drain
        G_WPTR = '0;
        do_reset();
        for (int w = 1; w <= 512; w++) begin
            G_WPTR = b2g(10'(w));
            tick();
        end
        ticks(5);
        chk("tp_full_level", 32'(R_LEVEL), 32'd512);
        chk("tp_full_empty", 32'(R_EMPTY), 32'd0);
        R_EN = 1'b1;
        for (int r = 1; r <= 512; r++) begin
            R_PTR_NXT = 10'(r);
            R_PTR = 10'(r - 1);
            tick();
        end
        R_EN = 1'b0;
        ticks(3);
        chk("tp_drain_empty", 32'(R_EMPTY), 32'd1);
        chk("tp_drain_level", 32'(R_LEVEL), 32'd0);

        // Wrap-around with a 3-entry offset (reset taken mid-operation)
        wb = 10'h3FE;
        rb = 10'h3FB;
        G_WPTR = b2g(wb);
        R_PTR_NXT = rb;
        do_reset();
        ticks(6);
        chk("tp_wrap_start", 32'(R_LEVEL), 32'd3);
        for (int i = 0; i < 8; i++) begin
            wb = wb + 10'd1;
            rb = rb + 10'd1;
            G_WPTR = b2g(wb);
            R_PTR_NXT = rb;
            tick();
        end
        ticks(5);
        chk("tp_wrap_end", 32'(R_LEVEL), 32'd3);

        // Sticky underflow: set, hold, set-beats-clear, clear alone
        R_EN = 1'b1; EMPTY = 1'b1;
        tick();
        R_EN = 1'b0; EMPTY = 1'b0;
        chk("tp_uf_set", 32'(R_UNDERFLOW), 32'd1);
        tick();
        chk("tp_uf_hold", 32'(R_UNDERFLOW), 32'd1);
        R_EN = 1'b1; EMPTY = 1'b1; R_UNDERFLOW_CLR = 1'b1;
        tick();
        chk("tp_uf_set_wins", 32'(R_UNDERFLOW), 32'd1);
        R_EN = 1'b0; EMPTY = 1'b0;
        tick();
        chk("tp_uf_clear", 32'(R_UNDERFLOW), 32'd0);
        R_UNDERFLOW_CLR = 1'b0;
        tick();

        // Random legal traffic with a mid-run reset
        wb = '0;
        rb = '0;
        G_WPTR = '0;
        R_PTR_NXT = '0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            if ($urandom_range(1, 0) == 1 && (wb - rb) != 10'h200) wb = wb + 10'd1;
            if ($urandom_range(1, 0) == 1 && rb != exp_b(k)) rb = rb + 10'd1;
            G_WPTR = b2g(wb);
            R_PTR_NXT = rb;
            R_PTR = rb - 10'd1;
            R_EN = 1'($urandom_range(1, 0));
            EMPTY = ($urandom_range(3, 0) == 0);
            R_UNDERFLOW_CLR = ($urandom_range(7, 0) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

`default_nettype wire
